// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
// HD44780 init commands and the FSM/source encodings.
package lcd_seq_pkg;

  typedef enum logic [1:0] {
    PWRUP,
    ISSUE,
    WAIT,
    IDLE
  } state_e;

  typedef enum logic {
    INIT,
    FIFO
  } src_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_xfer_t;

  localparam int INIT_LEN = 4;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx
  );
    logic [7:0] cmd;
    unique case (idx)
      2'd0: cmd = LCD_CMD_FUNCSET;
      2'd1: cmd = LCD_CMD_DISPON;
      2'd2: cmd = LCD_CMD_CLEAR;
      2'd3: cmd = LCD_CMD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Request port and LCD write-controller handshake bundle.
// The slave view is the sequencer; master is its environment.
interface lcd_cmd_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_rs;
  logic [7:0]  req_data;

  logic        lcd_start;
  logic [31:0] lcd_data_a;
  logic [31:0] lcd_data_b;
  logic        lcd_done;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    output lcd_done,
    input  req_ready,
    input  lcd_start,
    input  lcd_data_a,
    input  lcd_data_b
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    input  lcd_done,
    output req_ready,
    output lcd_start,
    output lcd_data_a,
    output lcd_data_b
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Request FIFO of {rs, data} entries with occupancy count.
// Power-of-two depth, so pointers wrap naturally.
module lcd_cmd_fifo
  import lcd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  lcd_xfer_t              wdata_i,
  output lcd_xfer_t              rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lcd_xfer_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = count_q == FULL_CNT;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q
            + (AW+1)'(do_push)
            - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Powers up the LCD, issues the HD44780 init sequence, then
// drains processor requests one write-controller transfer at a time.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int POWERUP_CYCLES = 2000000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                        clock,
  input  logic                        reset,
  lcd_cmd_sequencer_if.slave          bus,
  output logic                        init_done,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int MAXC =
    (POWERUP_CYCLES > TIMEOUT_CYCLES) ?
    POWERUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC);

  localparam logic [CW-1:0] PWR_LAST =
    CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] IDX_LAST =
    2'(INIT_LEN - 1);

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic          tmo_q, tmo_d;
  lcd_xfer_t     xfer_q, xfer_d;

  lcd_xfer_t     fifo_head;
  lcd_xfer_t     fifo_wdata;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          xfer_end;

  assign fifo_wdata = '{rs: bus.req_rs, data: bus.req_data};
  assign fifo_push  = bus.req_valid;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= PWRUP;
      src_q       <= INIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      tmo_q       <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      tmo_q       <= tmo_d;
      xfer_q      <= xfer_d;
    end
  end

  // done wins over a timeout landing in the same cycle
  assign xfer_end = bus.lcd_done || (cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          src_d   = INIT;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (xfer_end) begin
          if (!bus.lcd_done) begin
            tmo_d = 1'b1;
          end
          if (src_q == FIFO) begin
            state_d = IDLE;
          end else if (idx_q == IDX_LAST) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
          src_d   = FIFO;
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = PWRUP;
      end
    endcase
  end

  // the transfer is latched on entry to ISSUE so data is valid
  // alongside lcd_start and holds until the next ISSUE
  always_comb begin
    xfer_d = xfer_q;
    if (state_d == ISSUE) begin
      if (src_d == INIT) begin
        xfer_d = '{rs: 1'b0, data: init_cmd(idx_d)};
      end else begin
        xfer_d = fifo_head;
      end
    end
    fifo_pop       = (state_q == ISSUE) && (src_q == FIFO);
    bus.lcd_start  = state_q == ISSUE;
    bus.lcd_data_a = {31'b0, xfer_q.rs};
    bus.lcd_data_b = {24'b0, xfer_q.data};
    bus.req_ready  = !fifo_full;
    busy           = (state_q != IDLE) || !fifo_empty;
    init_done      = init_done_q;
    timeout_err    = tmo_q;
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench: expected LCD transfers are queued from the init
// table and accepted requests; a monitor pops them on each lcd_start.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH    = 4;
  localparam int PWR      = 8;
  localparam int TMO      = 16;
  localparam int DONE_LAT = 5;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          init_done;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int suppress_idx = -1;

  logic [8:0] exp_q[$];
  int model_count = 0;
  int pos_starts = 0;

  lcd_cmd_sequencer_if bus ();

  lcd_cmd_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .POWERUP_CYCLES (PWR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .init_done   (init_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void load_init();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endfunction

  // Reference model: accepted pushes extend the expected stream;
  // every transfer after the four init commands drains one entry.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_init();
      model_count = 0;
      pos_starts  = 0;
    end else begin
      if (bus.req_valid && model_count < DEPTH) begin
        exp_q.push_back({bus.req_rs, bus.req_data});
        model_count++;
      end
      if (bus.lcd_start) begin
        if (pos_starts >= 4) model_count--;
        pos_starts++;
      end
    end
  end

  // Write-controller model: done DONE_LAT cycles after start.
  int cd = 0;
  int ctl_idx = 0;
  always @(negedge clock) begin
    bus.lcd_done = 1'b0;
    if (!reset) begin
      cd      = 0;
      ctl_idx = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.lcd_done = 1'b1;
      end
      if (bus.lcd_start) begin
        if (ctl_idx != suppress_idx) cd = DONE_LAT;
        ctl_idx++;
      end
    end
  end

  // Monitor
  int         mon_idx = 0;
  int         last_start = 0;
  logic [63:0] last_ab = '0;
  logic       have_last = 1'b0;
  logic [8:0] e;
  int         gap_exp;
  always @(negedge clock) begin
    if (!reset) begin
      mon_idx   = 0;
      have_last = 1'b0;
    end else begin
      check("fifo_count", 64'(fifo_count), 64'(model_count));
      check("req_ready", 64'(bus.req_ready),
            64'(model_count < DEPTH));
      if (bus.lcd_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got a=%0h b=%0h expected no transfer",
                   bus.lcd_data_a, bus.lcd_data_b);
        end else begin
          e = exp_q.pop_front();
          check("data_a", 64'(bus.lcd_data_a), 64'({31'b0, e[8]}));
          check("data_b", 64'(bus.lcd_data_b), 64'({24'b0, e[7:0]}));
        end
        if (mon_idx >= 1 && mon_idx <= 3) begin
          gap_exp = (mon_idx - 1 == suppress_idx) ?
                    TMO + 1 : DONE_LAT + 1;
          check("init_gap", 64'(cyc - last_start), 64'(gap_exp));
        end
        last_start = cyc;
        mon_idx++;
        last_ab   = {bus.lcd_data_a, bus.lcd_data_b};
        have_last = 1'b1;
      end else if (have_last) begin
        check("data_hold", {bus.lcd_data_a, bus.lcd_data_b}, last_ab);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_start", 64'(bus.lcd_start), 64'(0));
    check("rst_data_a", 64'(bus.lcd_data_a), 64'(0));
    check("rst_data_b", 64'(bus.lcd_data_b), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_count", 64'(fifo_count), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs();
    #2 reset = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_data  = d;
    @(posedge clock);
    while (!bus.req_ready && n < 200) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL push_accept: got no req_ready expected acceptance within 200 cycles");
    end
    @(negedge clock);
  endtask

  task automatic drop();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_start(input int lim, input string name);
    int n = 0;
    while (!bus.lcd_start && n < lim) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!bus.lcd_start) begin
      errors++;
      $display("FAIL %s: got no lcd_start expected one within %0d cycles",
               name, lim);
    end
  endtask

  task automatic wait_idle(input int lim, input string name);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;

    // Power-up and init with no requests
    do_reset();
    wait_start(20, "first_start");
    check("powerup_wait", 64'(cyc - rel_cyc), 64'(PWR));
    wait_idle(200, "init_idle");
    check("init_done", 64'(init_done), 64'(1));
    check("no_timeout", 64'(timeout_err), 64'(0));
    check("init_drained", 64'(exp_q.size()), 64'(0));

    // Single data write after init
    push(1'b1, 8'h41);
    drop();
    c0 = cyc;
    wait_start(10, "single_start");
    check("issue_latency", 64'(cyc - c0), 64'(1));
    wait_idle(50, "single_idle");
    check("single_drained", 64'(exp_q.size()), 64'(0));

    // Fill during power-up; fifth entry held off until drain
    do_reset();
    push(1'b1, 8'h41);
    push(1'b1, 8'h42);
    push(1'b1, 8'h43);
    push(1'b1, 8'h44);
    check("full_count", 64'(fifo_count), 64'(DEPTH));
    check("full_ready", 64'(bus.req_ready), 64'(0));
    push(1'b1, 8'h45);
    drop();
    check("held_until_init", 64'(init_done), 64'(1));
    wait_idle(200, "burst_idle");
    check("burst_drained", 64'(exp_q.size()), 64'(0));

    // Second init command never completes
    suppress_idx = 1;
    do_reset();
    wait_idle(300, "tmo_idle");
    check("tmo_init_done", 64'(init_done), 64'(1));
    check("tmo_flag", 64'(timeout_err), 64'(1));
    push(1'b1, 8'h5A);
    drop();
    wait_idle(50, "tmo_push_idle");
    check("tmo_sticky", 64'(timeout_err), 64'(1));
    suppress_idx = -1;

    // Reset while a FIFO transfer is in WAIT with 2 queued
    push(1'b1, 8'h61);
    push(1'b1, 8'h62);
    push(1'b1, 8'h63);
    drop();
    check("pre_reset_count", 64'(fifo_count), 64'(2));
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    rel_cyc = cyc;
    wait_start(20, "rerun_start");
    check("rerun_powerup", 64'(cyc - rel_cyc), 64'(PWR));
    wait_idle(200, "rerun_idle");
    check("rerun_init_done", 64'(init_done), 64'(1));
    check("rerun_drained", 64'(exp_q.size()), 64'(0));

    // Push in the same cycle as a pop at 2 entries
    push(1'b1, 8'h71);
    push(1'b1, 8'h72);
    push(1'b1, 8'h73);
    drop();
    wait_start(20, "pp_start");
    push(1'b1, 8'h74);
    drop();
    check("push_pop_count", 64'(fifo_count), 64'(2));
    wait_idle(100, "pp_idle");
    check("pp_drained", 64'(exp_q.size()), 64'(0));

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clock);
      push(1'($urandom_range(0, 1)), 8'($urandom));
      drop();
    end
    wait_idle(600, "rand_idle");
    check("rand_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
